// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Byte address layout: [ tag | idx | off | 2'b00 ].
package cache_pkg;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int LINES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int IDX_W          = $clog2(LINES);
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } cache_state_t;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [OFF_W-1:0] off_t;

  function automatic idx_t addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W+2 +: IDX_W];
  endfunction

  function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic off_t addr_off(input logic [ADDR_W-1:0] a);
    return a[2 +: OFF_W];
  endfunction
endpackage

// File: rtl/icache_lookup_if.sv
// Bundle of the fetch-side lookup signals and the memory read port.
// Handshakes:
//   fetch side : req_valid is a level request; hit=1 in the same cycle completes it.
//   memory side: mem_req/mem_addr are held stable until a cycle with mem_valid=1,
//                which completes exactly one word transfer at that posedge.
// slave  : the cache itself.
// master : the environment (fetch unit + memory).
// dbg_state exposes the cache FSM state for observation.
interface icache_lookup_if;
  import cache_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              hit;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  cache_state_t      dbg_state;

  modport slave (
    input  req_valid, req_addr, flush, mem_valid, mem_rdata,
    output hit, rdata, busy, mem_req, mem_addr, dbg_state
  );

  modport master (
    output req_valid, req_addr, flush, mem_valid, mem_rdata,
    input  hit, rdata, busy, mem_req, mem_addr, dbg_state
  );
endinterface

// File: rtl/cache_line_store.sv
// Data array for the cache: LINES x WORDS_PER_LINE words.
// Ports: clk_i, one synchronous write port (we_i, widx_i, woff_i, wdata_i),
//        one combinational read port (ridx_i, roff_i -> rdata_o).
// Contents are not reset; the valid bits in the top qualify them.
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  idx_t              widx_i,
  input  off_t              woff_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  idx_t              ridx_i,
  input  off_t              roff_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [LINES][WORDS_PER_LINE];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[widx_i][woff_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i][roff_i];
endmodule

// File: rtl/icache_lookup.sv
// Direct-mapped read-only cache front end.
// Ports: clk, rst (synchronous, active high), bus (icache_lookup_if.slave):
//   fetch side req_valid/req_addr/flush -> hit/rdata/busy,
//   memory side mem_req/mem_addr -> mem_valid/mem_rdata.
// A hit is reported combinationally in IDLE. A miss refills the whole line one
// word per memory handshake, spends one FILL_DONE bubble, then returns to IDLE
// where the still-asserted request hits.
module icache_lookup
  import cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  icache_lookup_if.slave  bus
);
  cache_state_t      state_q, state_d;
  off_t              word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [LINES-1:0]  valid_q;
  tag_t              tag_q [LINES];

  logic              flush_all, fill_we, line_done;
  logic              hit, busy, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] store_rdata;

  idx_t req_idx, miss_idx;
  tag_t req_tag;
  off_t req_off;
  logic lookup_hit;

  assign req_idx    = addr_idx(bus.req_addr);
  assign req_tag    = addr_tag(bus.req_addr);
  assign req_off    = addr_off(bus.req_addr);
  assign miss_idx   = addr_idx(miss_addr_q);
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    miss_addr_d = miss_addr_q;
    flush_all   = 1'b0;
    fill_we     = 1'b0;
    line_done   = 1'b0;
    hit         = 1'b0;
    busy        = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    unique case (state_q)
      IDLE: begin
        hit = bus.req_valid && lookup_hit;
        // Flush takes priority over starting a refill; the lookup is still reported.
        if (bus.flush) begin
          flush_all = 1'b1;
        end else if (bus.req_valid && !lookup_hit) begin
          miss_addr_d = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
          word_cnt_d  = '0;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = miss_addr_q + ADDR_W'({word_cnt_q, 2'b00});
        if (bus.mem_valid) begin
          fill_we    = 1'b1;
          word_cnt_d = word_cnt_q + off_t'(1);
          if (word_cnt_q == off_t'(WORDS_PER_LINE - 1)) begin
            line_done = 1'b1;
            state_d   = FILL_DONE;
          end
        end
      end
      FILL_DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      miss_addr_q <= miss_addr_d;
      if (flush_all)      valid_q           <= '0;
      else if (line_done) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tags are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (line_done && !rst) tag_q[miss_idx] <= addr_tag(miss_addr_q);
  end

  cache_line_store u_store (
    .clk_i   (clk),
    .we_i    (fill_we && !rst),
    .widx_i  (miss_idx),
    .woff_i  (word_cnt_q),
    .wdata_i (bus.mem_rdata),
    .ridx_i  (req_idx),
    .roff_i  (req_off),
    .rdata_o (store_rdata)
  );

  assign bus.hit       = hit;
  assign bus.rdata     = hit ? store_rdata : '0;
  assign bus.busy      = busy;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_icache_lookup.sv
// Bench for icache_lookup: directed scenarios plus a randomized phase, checked
// against a line-level cache model and a memory-address scoreboard.
module tb_icache_lookup;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_lookup_if bus ();

  icache_lookup dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid [LINES];
  logic [23:0] m_tag   [LINES];

  // Backing memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return (a * 32'h9E3779B1) ^ 32'h5EED_C0DE;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // ---------------- memory responder / scoreboard ----------------
  logic [31:0] exp_q [$];     // word addresses the cache must fetch, in order
  int          mem_delay = 0; // idle cycles before each mem_valid
  int          wait_cnt  = 0;
  int          n_words   = 0;
  bit          stray_en  = 1'b0;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        if (exp_q.size() == 0) begin
          check("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
          bus.mem_valid = 1'b0;
        end else if (wait_cnt >= mem_delay) begin
          check("mem_addr", bus.mem_addr, exp_q.pop_front());
          bus.mem_rdata = mem_word(bus.mem_addr);
          bus.mem_valid = 1'b1;
          wait_cnt = 0;
          n_words++;
        end else begin
          check("mem_addr_stable", bus.mem_addr, exp_q[0]);
          bus.mem_valid = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_valid = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one lookup and hold it until it hits. disturb=1 scrambles req/flush
  // while the cache is busy, which the cache must ignore.
  task automatic do_req(input logic [31:0] addr, input bit disturb);
    logic [3:0]  idx;
    logic [23:0] tag;
    bit          exp_hit;
    bit          got;
    int          lat;
    idx = addr[7:4];
    tag = addr[31:8];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.flush     = 1'b0;
    #1;
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    check("hit", 32'(bus.hit), 32'(exp_hit));
    if (exp_hit) begin
      check("rdata_hit", bus.rdata, mem_word({addr[31:2], 2'b00}));
      check("mem_req_on_hit", 32'(bus.mem_req), 32'd0);
    end else begin
      check("rdata_miss", bus.rdata, 32'd0);
      for (int k = 0; k < WORDS_PER_LINE; k++) exp_q.push_back(line_base(addr) + 32'(k * 4));
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 400; c++) begin
        @(negedge clk);
        if (disturb && bus.busy) begin
          bus.req_valid = 1'($urandom_range(0, 1));
          bus.req_addr  = $urandom;
          bus.flush     = 1'b1;
        end else begin
          bus.req_valid = 1'b1;
          bus.req_addr  = addr;
          bus.flush     = 1'b0;
        end
        #1;
        if (c == 1) begin
          check("busy_refill", 32'(bus.busy), 32'd1);
          check("mem_req_refill", 32'(bus.mem_req), 32'd1);
          check("hit_refill", 32'(bus.hit), 32'd0);
        end
        if (bus.hit) begin
          got = 1'b1;
          lat = c;
          break;
        end
      end
      check("fill_completed", 32'(got), 32'd1);
      check("miss_latency", 32'(lat), 32'(WORDS_PER_LINE * (mem_delay + 1) + 2));
      check("rdata_after_fill", bus.rdata, mem_word({addr[31:2], 2'b00}));
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_clear();
  endtask

  // Flush and lookup in the same cycle: lookup reported, no refill, lines cleared.
  task automatic do_flush_req(input logic [31:0] addr);
    bit exp_hit;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.flush     = 1'b1;
    #1;
    exp_hit = m_valid[addr[7:4]] && (m_tag[addr[7:4]] == addr[31:8]);
    check("flush_req_hit", 32'(bus.hit), 32'(exp_hit));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check("flush_req_no_refill", 32'(bus.mem_req), 32'd0);
    check("flush_req_not_busy", 32'(bus.busy), 32'd0);
    model_clear();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [23:0] t;
    logic [3:0]  i;
    t = 24'($urandom_range(0, 3) * 32'h1001);
    i = 4'($urandom_range(0, 3));
    return {t, i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    model_clear();

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;

    // Cold miss, then warm hits on the filled line.
    do_req(32'h0000_0104, 1'b0);
    do_req(32'h0000_010C, 1'b0);
    do_req(32'h0000_0100, 1'b0);

    // Conflict eviction on idx 0, then the original line misses again.
    do_req(32'h0000_0204, 1'b0);
    do_req(32'h0000_0208, 1'b0);
    do_req(32'h0000_0104, 1'b0);

    // Flush in IDLE, then refill with flush/req noise during the refill.
    do_flush();
    do_req(32'h0000_0104, 1'b1);
    do_req(32'h0000_0108, 1'b0);
    do_flush_req(32'h0000_0104);
    do_req(32'h0000_0104, 1'b0);

    // Reset in the middle of a refill.
    do_flush();
    begin
      int snap;
      bit reached;
      snap = n_words;
      reached = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0104;
      for (int k = 0; k < WORDS_PER_LINE; k++) exp_q.push_back(32'h100 + 32'(k * 4));
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (n_words >= snap + 2) begin
          reached = 1'b1;
          break;
        end
      end
      check("rst_mid_reached", 32'(reached), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      wait_cnt = 0;
      #1;
      check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      model_clear();
    end
    do_req(32'h0000_0104, 1'b0);

    // Stalled memory, then stray mem_valid in IDLE must not corrupt the line.
    mem_delay = 5;
    do_req(32'h0000_3340, 1'b0);
    mem_delay = 0;
    stray_en = 1'b1;
    repeat (8) @(negedge clk);
    stray_en = 1'b0;
    for (int k = 0; k < WORDS_PER_LINE; k++) do_req(32'h0000_3340 + 32'(k * 4), 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      mem_delay = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) do_flush();
      else if ($urandom_range(0, 14) == 0) do_flush_req(rand_addr());
      else do_req(rand_addr(), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
